// File: rtl/spi_slave_fl_if.sv
// spi_slave_fl_if: pin and backend bundle for the SPI flash responder.
//   SPI side     : sclk, ss (active low), mosi -> target; miso, miso_oe <- target
//   header       : cmd, addr, hdr_valid
//   read backend : rd_req <- target; rd_valid, rd_data -> target
//   write backend: wr_valid, wr_data <- target
//   status       : frame_done, underrun
// Modport slave is the responder itself; modport master is the flash master
// plus byte backend that surround it.
`timescale 1ns/1ps
interface spi_slave_fl_if;
  logic        sclk;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic        hdr_valid;
  logic        rd_req;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        frame_done;
  logic        underrun;

  modport slave (
    input  sclk, ss, mosi, rd_valid, rd_data,
    output miso, miso_oe, cmd, addr, hdr_valid, rd_req,
           wr_valid, wr_data, frame_done, underrun
  );

  modport master (
    output sclk, ss, mosi, rd_valid, rd_data,
    input  miso, miso_oe, cmd, addr, hdr_valid, rd_req,
           wr_valid, wr_data, frame_done, underrun
  );
endinterface

// File: rtl/spi_slave_fl.sv
// spi_slave_fl: single-lane SPI flash responder, oversampled in the clk domain.
// Decodes a command byte plus optional 24-bit address, then streams bytes to
// (DOUT) or from (DIN) a byte-wide backend.
//   clk : system clock, all logic on the rising edge
//   rst : synchronous, active-low reset
//   bus : spi_slave_fl_if.slave (SPI pins, header outputs, rd/wr handshakes)
// Parameters CPOL/CPHA select the SPI mode (default mode 3).
// Optional build macro SPI_SLAVE_FASTREAD_EN adds FAST READ (0x0B) with an
// 8-clock DUMMY phase; without it 0x0B is discarded like any unknown opcode.
`timescale 1ns/1ps
module spi_slave_fl #(
  parameter bit CPOL = 1'b1,
  parameter bit CPHA = 1'b1
) (
  input logic           clk,
  input logic           rst,
  spi_slave_fl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR,
`ifdef SPI_SLAVE_FASTREAD_EN
    DUMMY,
`endif
    DOUT, DIN, DISCARD
  } state_t;

  // Pin synchronizers (stages 1-2) and registered edge detector (stage 3).
  logic [1:0] sclk_sync, ss_sync, mosi_sync;
  logic       sclk_q, ss_q, ss_fall_q, mosi_q, smp_q, drv_q;
  logic       rise, fall, lead, trail;

  assign rise  = sclk_sync[1] & ~sclk_q;
  assign fall  = ~sclk_sync[1] & sclk_q;
  assign lead  = CPOL ? fall : rise;
  assign trail = CPOL ? rise : fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: ss history resets low so a select already low when reset lifts
      // never looks like a fresh falling edge; the frame waits for a real one.
      sclk_sync <= {2{CPOL}};
      sclk_q    <= CPOL;
      ss_sync   <= 2'b00;
      ss_q      <= 1'b0;
      ss_fall_q <= 1'b0;
      mosi_sync <= 2'b00;
      mosi_q    <= 1'b0;
      smp_q     <= 1'b0;
      drv_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere in clocked blocks so every stage samples
      // the previous stage's old value, giving a true shift pipeline.
      sclk_sync <= {sclk_sync[0], bus.sclk};
      ss_sync   <= {ss_sync[0], bus.ss};
      mosi_sync <= {mosi_sync[0], bus.mosi};
      sclk_q    <= sclk_sync[1];
      ss_q      <= ss_sync[1];
      ss_fall_q <= ss_q & ~ss_sync[1];
      mosi_q    <= mosi_sync[1];
      smp_q     <= CPHA ? trail : lead;
      drv_q     <= CPHA ? lead : trail;
    end
  end

  // Protocol state and registered outputs.
  state_t      state, state_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift_in, shift_in_n, sh_out, sh_out_n;
  logic [7:0]  buf_data, buf_data_n;
  logic        buf_full, buf_full_n;
  logic [1:0]  rd_win, rd_win_n;      // cycles left in which rd_valid is accepted
  logic        addr_inc, addr_inc_n;
  logic        miso_q, miso_n, miso_oe_q, miso_oe_n;
  logic [7:0]  cmd_q, cmd_n, wr_data_q, wr_data_n;
  logic [23:0] addr_q, addr_n;
  logic        hdr_valid_q, hdr_valid_n, rd_req_q, rd_req_n;
  logic        wr_valid_q, wr_valid_n, frame_done_q, frame_done_n;
  logic        underrun_q, underrun_n;
  logic [7:0]  byte_in, load_src;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_in     <= '0;
      sh_out       <= 8'hFF;
      buf_data     <= '0;
      buf_full     <= 1'b0;
      rd_win       <= '0;
      addr_inc     <= 1'b0;
      miso_q       <= 1'b1;
      miso_oe_q    <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      hdr_valid_q  <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      shift_in     <= shift_in_n;
      sh_out       <= sh_out_n;
      buf_data     <= buf_data_n;
      buf_full     <= buf_full_n;
      rd_win       <= rd_win_n;
      addr_inc     <= addr_inc_n;
      miso_q       <= miso_n;
      miso_oe_q    <= miso_oe_n;
      cmd_q        <= cmd_n;
      addr_q       <= addr_n;
      wr_data_q    <= wr_data_n;
      hdr_valid_q  <= hdr_valid_n;
      rd_req_q     <= rd_req_n;
      wr_valid_q   <= wr_valid_n;
      frame_done_q <= frame_done_n;
      underrun_q   <= underrun_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case below can leave one unassigned and infer a latch.
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_in_n   = shift_in;
    sh_out_n     = sh_out;
    buf_data_n   = buf_data;
    buf_full_n   = buf_full;
    rd_win_n     = (rd_win != 2'd0) ? rd_win - 2'd1 : 2'd0;
    addr_inc_n   = 1'b0;
    miso_n       = miso_q;
    miso_oe_n    = miso_oe_q;
    cmd_n        = cmd_q;
    addr_n       = addr_inc ? addr_q + 24'd1 : addr_q;
    wr_data_n    = wr_data_q;
    hdr_valid_n  = 1'b0;
    rd_req_n     = 1'b0;
    wr_valid_n   = 1'b0;
    underrun_n   = underrun_q;
    frame_done_n = ss_sync[1] & ~ss_q & (state != IDLE);
    byte_in      = {shift_in[6:0], mosi_q};
    load_src     = buf_full ? buf_data : 8'hFF;

    // Prefetch capture; only inside the window opened by our own rd_req.
    if (bus.rd_valid && rd_win != 2'd0) begin
      buf_data_n = bus.rd_data;
      buf_full_n = 1'b1;
      rd_win_n   = 2'd0;
    end

    // Deselect beats everything, including an SMP edge seen the same cycle.
    if (ss_q) begin
      state_n    = IDLE;
      bit_cnt_n  = '0;
      miso_n     = 1'b1;
      miso_oe_n  = 1'b0;
      buf_full_n = 1'b0;
      rd_win_n   = 2'd0;
    end else begin
      case (state)
        IDLE: if (ss_fall_q) begin
          state_n    = CMD;
          bit_cnt_n  = '0;
          underrun_n = 1'b0;
        end
        CMD: if (smp_q) begin
          shift_in_n = byte_in;
          bit_cnt_n  = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            cmd_n     = byte_in;
            bit_cnt_n = '0;
            case (byte_in)
              8'h03, 8'h02: state_n = ADDR;
`ifdef SPI_SLAVE_FASTREAD_EN
              8'h0B:        state_n = ADDR;
`endif
              8'h9F, 8'h05: begin
                addr_n      = '0;
                hdr_valid_n = 1'b1;
                rd_req_n    = 1'b1;
                state_n     = DOUT;
              end
              8'h06, 8'h04: begin
                hdr_valid_n = 1'b1;
                state_n     = DISCARD;
              end
              default:      state_n = DISCARD;
            endcase
          end
        end
        ADDR: if (smp_q) begin
          addr_n    = {addr_q[22:0], mosi_q};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd23) begin
            bit_cnt_n   = '0;
            hdr_valid_n = 1'b1;
            case (cmd_q)
              8'h03: begin
                rd_req_n = 1'b1;
                state_n  = DOUT;
              end
              8'h02:   state_n = DIN;
`ifdef SPI_SLAVE_FASTREAD_EN
              8'h0B:   state_n = DUMMY;
`endif
              default: state_n = DISCARD;
            endcase
          end
        end
`ifdef SPI_SLAVE_FASTREAD_EN
        DUMMY: if (smp_q) begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            bit_cnt_n = '0;
            rd_req_n  = 1'b1;
            state_n   = DOUT;
          end
        end
`endif
        DOUT: if (drv_q) begin
          miso_oe_n = 1'b1;
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt[2:0] == 3'd0) begin
            // Byte boundary: a capture landing this same cycle is too late.
            miso_n     = load_src[7];
            sh_out_n   = {load_src[6:0], 1'b1};
            buf_full_n = 1'b0;
            addr_n     = addr_q + 24'd1;
            rd_req_n   = 1'b1;
            if (!buf_full) underrun_n = 1'b1;
          end else begin
            miso_n   = sh_out[7];
            sh_out_n = {sh_out[6:0], 1'b1};
          end
        end
        DIN: if (smp_q) begin
          shift_in_n = byte_in;
          bit_cnt_n  = bit_cnt + 5'd1;
          if (bit_cnt[2:0] == 3'd7) begin
            wr_data_n  = byte_in;
            wr_valid_n = 1'b1;
            addr_inc_n = 1'b1;
          end
        end
        DISCARD: ;
        default: state_n = IDLE;
      endcase
    end

    if (rd_req_n) rd_win_n = 2'd3;
  end

  assign bus.miso       = miso_q;
  assign bus.miso_oe    = miso_oe_q;
  assign bus.cmd        = cmd_q;
  assign bus.addr       = addr_q;
  assign bus.hdr_valid  = hdr_valid_q;
  assign bus.rd_req     = rd_req_q;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_spi_slave_fl.sv
// tb_spi_slave_fl: mode-3 flash master + byte backend around spi_slave_fl.
// Expected bytes, addresses and header words come from a transaction-level
// model (queues of bytes, address arithmetic modulo 2^24).
`timescale 1ns/1ps
module tb_spi_slave_fl;
  localparam int HALF = 6;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b0;

  spi_slave_fl_if bus ();
  spi_slave_fl #(.CPOL(1'b1), .CPHA(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [31:0] hdr_log[$];   // {cmd, addr} at each hdr_valid
  logic [23:0] req_log[$];   // addr at each rd_req
  logic [31:0] wr_log[$];    // {wr_data, addr} at each wr_valid
  int          fd_cnt = 0;
  bit          oe_seen = 1'b0;
  bit          be_on = 1'b1;
  logic [7:0]  be_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.hdr_valid === 1'b1)  hdr_log.push_back({bus.cmd, bus.addr});
      if (bus.rd_req === 1'b1)     req_log.push_back(bus.addr);
      if (bus.wr_valid === 1'b1)   wr_log.push_back({bus.wr_data, bus.addr});
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.miso_oe === 1'b1)    oe_seen = 1'b1;
    end
  end

  // Read backend: answers each rd_req one cycle later from be_q.
  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rd_req === 1'b1 && be_on) begin
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_data  = (be_q.size() > 0) ? be_q.pop_front() : 8'h00;
        @(negedge clk);
        bus.rd_valid = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic clear_logs();
    hdr_log.delete();
    req_log.delete();
    wr_log.delete();
    fd_cnt  = 0;
    oe_seen = 1'b0;
  endtask

  // Mode 3: drive mosi on falling sclk, sample miso just before rising sclk.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx, output logic oe);
    rx = 8'h00;
    oe = 1'b1;
    for (int i = 7; i > 7 - n; i--) begin
      bus.sclk = 1'b0;
      bus.mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], bus.miso};
      oe = oe & bus.miso_oe;
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe);
    spi_bits(tx, 8, rx, oe);
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [23:0] a);
    logic [7:0] rx;
    logic       oe;
    spi_byte(c, rx, oe);
    spi_byte(a[23:16], rx, oe);
    spi_byte(a[15:8], rx, oe);
    spi_byte(a[7:0], rx, oe);
  endtask

  task automatic ss_begin();
    bus.ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_end();
    bus.ss = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  rx, d;
    logic        oe;
    logic [23:0] a;
    logic [7:0]  exp_bytes[$];

    bus.sclk = 1'b1;
    bus.ss   = 1'b1;
    bus.mosi = 1'b0;
    repeat (4) @(negedge clk);

    // Reset values.
    check("rst_miso", bus.miso, 1'b1);
    check("rst_miso_oe", bus.miso_oe, 1'b0);
    check("rst_cmd", bus.cmd, 8'h00);
    check("rst_addr", bus.addr, 24'h0);
    check("rst_wr_data", bus.wr_data, 8'h00);
    check("rst_underrun", bus.underrun, 1'b0);
    check("rst_pulses", {bus.hdr_valid, bus.rd_req, bus.wr_valid, bus.frame_done}, 4'b0000);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // READ 0x012345, backend supplies A5, 3C.
    clear_logs();
    be_q = '{8'hA5, 8'h3C};
    ss_begin();
    send_hdr(8'h03, 24'h012345);
    spi_byte(8'h00, rx, oe);
    check("rd_byte0", rx, 8'hA5);
    check("rd_oe0", oe, 1'b1);
    spi_byte(8'h00, rx, oe);
    check("rd_byte1", rx, 8'h3C);
    check("rd_hdr_cnt", hdr_log.size(), 1);
    check("rd_hdr", hdr_log[0], {8'h03, 24'h012345});
    check("rd_req_cnt", req_log.size(), 3);
    check("rd_req0", req_log[0], 24'h012345);
    check("rd_req1", req_log[1], 24'h012346);
    bus.ss = 1'b1;
    repeat (2) @(negedge clk);
    check("fd_early", bus.frame_done, 1'b0);
    @(negedge clk);
    check("fd_pulse", bus.frame_done, 1'b1);
    @(negedge clk);
    check("fd_after", bus.frame_done, 1'b0);
    repeat (8) @(negedge clk);
    check("rd_oe_off", bus.miso_oe, 1'b0);
    check("rd_no_underrun", bus.underrun, 1'b0);

    // PROGRAM at 0xFFFFFF wraps to 0.
    clear_logs();
    ss_begin();
    send_hdr(8'h02, 24'hFFFFFF);
    spi_byte(8'h11, rx, oe);
    spi_byte(8'h22, rx, oe);
    ss_end();
    check("pg_hdr", hdr_log[0], {8'h02, 24'hFFFFFF});
    check("pg_wr_cnt", wr_log.size(), 2);
    check("pg_wr0", wr_log[0], {8'h11, 24'hFFFFFF});
    check("pg_wr1", wr_log[1], {8'h22, 24'h000000});
    check("pg_no_req", req_log.size(), 0);
    check("pg_no_oe", oe_seen, 1'b0);

    // Random READs.
    for (int t = 0; t < 2; t++) begin
      clear_logs();
      a = 24'($urandom);
      exp_bytes.delete();
      for (int i = 0; i < 3; i++) begin
        d = 8'($urandom);
        exp_bytes.push_back(d);
        be_q.push_back(d);
      end
      ss_begin();
      send_hdr(8'h03, a);
      for (int i = 0; i < 3; i++) begin
        spi_byte(8'($urandom), rx, oe);
        check("rrd_byte", rx, exp_bytes[i]);
      end
      ss_end();
      check("rrd_req_cnt", req_log.size(), 4);
      for (int i = 0; i < 4; i++) check("rrd_req_addr", req_log[i], a + 24'(i));
      check("rrd_hdr", hdr_log[0], {8'h03, a});
    end

    // Random PROGRAMs, second one straddles the wrap.
    for (int t = 0; t < 2; t++) begin
      clear_logs();
      a = (t == 0) ? 24'($urandom) : 24'hFFFFFE;
      exp_bytes.delete();
      ss_begin();
      send_hdr(8'h02, a);
      for (int i = 0; i < 3; i++) begin
        d = 8'($urandom);
        exp_bytes.push_back(d);
        spi_byte(d, rx, oe);
      end
      ss_end();
      check("rpg_wr_cnt", wr_log.size(), 3);
      for (int i = 0; i < 3; i++) check("rpg_wr", wr_log[i], {exp_bytes[i], a + 24'(i)});
    end

    // READ with a silent backend: 0xFF bytes and sticky underrun.
    clear_logs();
    be_on = 1'b0;
    ss_begin();
    send_hdr(8'h03, 24'($urandom));
    spi_byte(8'h00, rx, oe);
    check("ur_byte0", rx, 8'hFF);
    spi_byte(8'h00, rx, oe);
    check("ur_byte1", rx, 8'hFF);
    ss_end();
    check("ur_sticky", bus.underrun, 1'b1);
    be_on = 1'b1;

    // Next select clears underrun; PROGRAM aborted after 5 data bits.
    clear_logs();
    ss_begin();
    check("ur_cleared", bus.underrun, 1'b0);
    send_hdr(8'h02, 24'($urandom));
    spi_bits(8'($urandom), 5, rx, oe);
    ss_end();
    check("ab_no_wr", wr_log.size(), 0);
    check("ab_frame_done", fd_cnt, 1);
    check("ab_oe_off", bus.miso_oe, 1'b0);

    // Unknown opcode 0x5A then 16 bits.
    clear_logs();
    ss_begin();
    spi_byte(8'h5A, rx, oe);
    spi_byte(8'($urandom), rx, oe);
    spi_byte(8'($urandom), rx, oe);
    ss_end();
    check("unk_no_evt", {hdr_log.size() != 0, req_log.size() != 0, wr_log.size() != 0}, 3'b000);
    check("unk_no_oe", oe_seen, 1'b0);

    // READ ID 0x9F: address forced to 0, data follows the opcode directly.
    clear_logs();
    d = 8'($urandom);
    be_q.push_back(d);
    ss_begin();
    spi_byte(8'h9F, rx, oe);
    spi_byte(8'h00, rx, oe);
    check("id_byte", rx, d);
    ss_end();
    check("id_hdr", hdr_log[0], {8'h9F, 24'h000000});
    check("id_req0", req_log[0], 24'h000000);

`ifdef SPI_SLAVE_FASTREAD_EN
    // FAST READ 0x0B at 0x000010 with 8 dummy clocks.
    clear_logs();
    d = 8'($urandom);
    be_q.push_back(d);
    ss_begin();
    send_hdr(8'h0B, 24'h000010);
    check("fr_hdr", hdr_log[0], {8'h0B, 24'h000010});
    spi_bits(8'h00, 7, rx, oe);
    check("fr_no_early_req", req_log.size(), 0);
    spi_bits(8'h00, 1, rx, oe);
    check("fr_req_cnt", req_log.size(), 1);
    check("fr_req_addr", req_log[0], 24'h000010);
    spi_byte(8'h00, rx, oe);
    check("fr_byte", rx, d);
    check("fr_oe", oe, 1'b1);
    ss_end();
`else
    // Without FAST READ support 0x0B is discarded.
    clear_logs();
    ss_begin();
    send_hdr(8'h0B, 24'h000010);
    spi_byte(8'h00, rx, oe);
    ss_end();
    check("fr_off_no_evt", {hdr_log.size() != 0, req_log.size() != 0, wr_log.size() != 0}, 3'b000);
    check("fr_off_no_oe", oe_seen, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
